// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// ALU operation classes/codes and datapath mux selects.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
   } state_t;

   typedef enum logic [1:0] {
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNC
   } alu_op_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;
   localparam logic [1:0] SRC_A_ZERO  = 2'b11;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_ALUOUT = 1'b1;

   // Only BEQ (000) and BNE (001) are implemented.
   function automatic logic branch_func3_ok(input logic [2:0] func3);
      return func3[2:1] == 2'b00;
   endfunction

   function automatic logic branch_taken(input logic [2:0] func3, input logic zero);
      return (func3 == 3'b000 && zero) || (func3 == 3'b001 && !zero);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from operation class, func3 and func7.
// Purely combinational, no latency; no flow control.
// R-type func7 outside 0000000/0100000 flags illegal and drives the all-ones code.
module alu_decoder
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 4
) (
   input  alu_op_t               alu_op,
   input  logic [2:0]            func3,
   input  logic [6:0]            func7,
   input  logic                  op5,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  illegal
);

   if (ALU_CTRL_W < 4) begin : g_bad_width
      $error("alu_decoder: ALU_CTRL_W must be at least 4");
   end

   logic [3:0] code;

   always_comb begin
      code    = ALU_ADD;
      illegal = 1'b0;
      unique case (alu_op)
         ALU_OP_ADD: code = ALU_ADD;
         ALU_OP_SUB: code = ALU_SUB;
         ALU_OP_FUNC: begin
            // op5 distinguishes R-type (register operand) from I-type.
            if (op5 && func7 != 7'b0000000 && func7 != 7'b0100000)
               illegal = 1'b1;
            case (func3)
               3'b000:  code = (op5 && func7[5]) ? ALU_SUB : ALU_ADD;
               3'b001:  code = ALU_SLL;
               3'b010:  code = ALU_SLT;
               3'b011:  code = ALU_SLTU;
               3'b100:  code = ALU_XOR;
               3'b101:  code = func7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  code = ALU_OR;
               default: code = ALU_AND;
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign alu_control = illegal ? '1 : ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM driving datapath muxes and enables.
// CPI 3-5 plus one cycle per memory wait; outputs combinational from state and inputs.
// mem_req held until mem_ready; no enable asserted on a wait cycle.
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W      = 4,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            op_code,
   input  logic [2:0]            func3,
   input  logic [6:0]            func7,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  mem_write,
   output logic                  adr_src,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic                  reg_write,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            result_src,
   output logic [2:0]            imm_type,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  illegal_instr,
   output logic                  instr_done
);

   state_t  state;
   alu_op_t alu_op;
   logic    dec_illegal;

   alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
      .alu_op      (alu_op),
      .func3       (func3),
      .func7       (func7),
      .op5         (op_code[5]),
      .alu_control (alu_control),
      .illegal     (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:     state <= S_FETCH;
            S_FETCH:    if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               case (op_code)
                  OP_LOAD, OP_STORE: state <= S_MEM_ADR;
                  OP_R:              state <= S_EXEC_R;
                  OP_I:              state <= S_EXEC_I;
                  OP_BRANCH:         state <= S_BRANCH;
                  OP_JAL:            state <= S_JAL;
                  OP_LUI:            state <= S_LUI;
                  default:           state <= S_ILLEGAL;
               endcase
            end
            S_MEM_ADR:   state <= (op_code == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
            S_MEM_WB:    state <= S_FETCH;
            S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
            // Bad R-type func7 is only visible once the decoder runs the FUNC class.
            S_EXEC_R:    state <= dec_illegal ? S_ILLEGAL : S_ALU_WB;
            S_EXEC_I:    state <= S_ALU_WB;
            S_ALU_WB:    state <= S_FETCH;
            S_BRANCH:    state <= branch_func3_ok(func3) ? S_FETCH : S_ILLEGAL;
            S_JAL:       state <= S_FETCH;
            S_LUI:       state <= S_ALU_WB;
            S_ILLEGAL:   state <= TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:     state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = ADR_PC;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RS2;
      result_src    = RES_ALUOUT;
      imm_type      = IMM_I;
      alu_op        = ALU_OP_ADD;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
      unique case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            adr_src = ADR_PC;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               alu_src_a  = SRC_A_PC;
               alu_src_b  = SRC_B_FOUR;
               result_src = RES_ALU;
            end
         end
         S_DECODE: begin
            // Precompute the branch or jump target into ALUOut.
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            imm_type  = (op_code == OP_JAL) ? IMM_J : IMM_B;
         end
         S_MEM_ADR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            imm_type  = (op_code == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEM_READ: begin
            mem_req = 1'b1;
            adr_src = ADR_ALUOUT;
         end
         S_MEM_WB: begin
            result_src = RES_MEM;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_req    = 1'b1;
            mem_write  = 1'b1;
            adr_src    = ADR_ALUOUT;
            instr_done = mem_ready;
         end
         S_EXEC_R: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_OP_FUNC;
         end
         S_EXEC_I: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            imm_type  = IMM_I;
            alu_op    = ALU_OP_FUNC;
         end
         S_ALU_WB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALU_OP_SUB;
            result_src = RES_ALUOUT;
            pc_write   = branch_taken(func3, zero);
            instr_done = branch_func3_ok(func3);
         end
         S_JAL: begin
            alu_src_a  = SRC_A_OLDPC;
            alu_src_b  = SRC_B_FOUR;
            imm_type   = IMM_J;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
            imm_type  = IMM_U;
         end
         S_ILLEGAL: illegal_instr = 1'b1;
         default: ;
      endcase
   end

endmodule
